jk_cmd_seq: RTL and testbench
=============================

// Module: jk_cmd_seq
// PURPOSE
//  Upstream driver for the asynchronous-reset JK flip-flop stage. Accepts queued
//  drive commands (HOLD/CLEAR/SET/TOGGLE, each with a repeat count) over a
//  valid/ready handshake. Plays each command out on registered j/k outputs for
//  count+1 cycles, and keeps a cycle-accurate model of the downstream q.
// PARAMETERS
//  DEPTH  4  command FIFO entries (power of 2, >=2)
//  CNT_W  4  repeat-count width; a command drives for count+1 cycles (1..2^CNT_W)
// PORTS
//  clk        in   1      rising-edge clock, shared with downstream JK stage
//  reset      in   1      asynchronous, active-low; 0 = reset
//  cmd_valid  in   1      command present
//  cmd_op     in   2      00 HOLD(j0k0) 01 CLEAR(j0k1) 10 SET(j1k0) 11 TOGGLE(j1k1)
//  cmd_cnt    in   CNT_W  repeat count
//  cmd_ready  out  1      FIFO can accept (combinational: !full)
//  j          out  1      registered J to downstream flop
//  k          out  1      registered K to downstream flop
//  busy       out  1      DRIVE state active or FIFO non-empty
//  done       out  1      1-cycle pulse during the final drive cycle of a command
//  q_model    out  1      expected downstream q after each edge
//  q          in   1      actual q fed back from downstream flop (used only with CHECK)
//  err        out  1      sticky q/q_model mismatch flag
// BEHAVIOUR
//  - Reset (reset=0, async): FIFO flushed; state IDLE; j=k=0; done=0; busy=0;
//    q_model=0; err=0. cmd_ready=1 once reset deasserts.
//  - Push: a command is accepted on an edge with cmd_valid & cmd_ready.
//    Full FIFO: cmd_ready=0, even if a pop happens in the same cycle.
//  - FSM IDLE: FIFO non-empty -> pop the head, load op/remaining=cnt, go to DRIVE.
//    j/k take op values at that same edge.
//    With the FIFO empty, j=k=0.
//  - FSM DRIVE: each edge decrements remaining.
//    When remaining==0 the cycle is final: done=1.
//    Final cycle with the FIFO non-empty: next head popped at that edge, no bubble.
//    Final cycle with the FIFO empty: IDLE, j=k=0.
//  - Latency: command accepted at edge N into an idle, empty block -> j/k valid
//    after edge N+1 and held for cnt+1 cycles.
//  - Simultaneous push and pop: both occur, and occupancy is unchanged.
//    Push into an empty FIFO while IDLE is not bypassed (pop on the next edge).
//  - q_model updates every edge from the j/k currently driven:
//    00 hold, 01 ->0, 10 ->1, 11 invert.
//    It matches the downstream flop, which samples the same j/k on the same edge.
//  - Pointers wrap modulo DEPTH; the count field wraps only by reload, never underflows.
//  - Reset mid-DRIVE: command aborted, queued commands discarded, no done pulse.
// CONFIGURATION
//  JK_SEQ_CHECK_EN defined:
//    - q is sampled each edge and compared to q_model's pre-edge value.
//    - A mismatch sets err, which stays 1 until reset.
//  JK_SEQ_CHECK_EN undefined:
//    - Comparator omitted; q ignored; err tied 0.
// TESTING
//  1 Reset low 100ns, release; no commands -> j=k=0, cmd_ready=1, busy=0, q_model=0.
//  2 Push SET cnt=0 -> j=1,k=0 for exactly 1 cycle with done=1 -> q_model=1, then j=k=0.
//  3 After SET, push TOGGLE cnt=3 -> j=k=1 for 4 cycles, q_model 0,1,0,1 -> ends 1, done on 4th cycle.
//  4 Push CLEAR cnt=15, then 5 more commands back-to-back -> cmd_ready=0 after DEPTH queued.
//    The drain then runs with no idle bubbles between commands.
//  5 Assert reset during cycle 3 of TOGGLE cnt=7 with 2 queued -> j=k=0, q_model=0,
//    busy=0 immediately, no done pulse.
//  6 CHECK_EN: drive SET and force q=0 -> err=1 one edge later and stays 1 across commands until reset.

Source files
------------

// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: queued HOLD/CLEAR/SET/TOGGLE driver for a downstream JK flop.
// Define JK_SEQ_CHECK_EN to compare the fed-back q against q_model.
module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             cmd_ready,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             q_model,
  input  logic             q,
  output logic             err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  logic [1:0]       op_mem  [DEPTH];
  logic [CNT_W-1:0] cnt_mem [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      used;

  state_t           state;
  logic [CNT_W-1:0] remaining;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic last;

  assign empty     = (used == '0);
  assign full      = (used == FULL_CNT);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign last      = (state == DRIVE) && (remaining == '0);
  assign pop       = !empty && ((state == IDLE) || last);
  assign busy      = (state == DRIVE) || !empty;

  // Storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= cmd_op;
      cnt_mem[wr_ptr] <= cmd_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   used <= used + (AW+1)'(1);
        2'b01:   used <= used - (AW+1)'(1);
        default: used <= used;
      endcase
    end
  end

  // A pop on the final drive cycle chains the next command with no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (1'b1)
        pop: begin
          state     <= DRIVE;
          remaining <= cnt_mem[rd_ptr];
          j         <= op_mem[rd_ptr][1];
          k         <= op_mem[rd_ptr][0];
          done      <= (cnt_mem[rd_ptr] == '0);
        end
        (state == DRIVE) && !last: begin
          remaining <= remaining - CNT_W'(1);
          done      <= (remaining == CNT_W'(1));
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
          j         <= 1'b0;
          k         <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_model <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= !q_model;
        default: q_model <= q_model;
      endcase
    end
  end

`ifdef JK_SEQ_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err <= 1'b0;
    else if (q != q_model)
      err <= 1'b1;
  end
`else
  logic unused_q;
  assign unused_q = q;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// tb_jk_cmd_seq: directed + random stimulus against a queue-based
// reference model of the command sequencer.
module tb_jk_cmd_seq;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = '0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic             q_in = 1'b0;
  logic             cmd_ready;
  logic             j;
  logic             k;
  logic             busy;
  logic             done;
  logic             q_model;
  logic             err;

  int total = 0;
  int bad   = 0;

  logic [CNT_W+1:0] fq[$];
  bit               act;
  logic [1:0]       m_op;
  int               m_rem;
  bit               m_q;
  bit               m_err;
  bit               force_q0;

  jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_ready (cmd_ready),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .q_model   (q_model),
    .q         (q_in),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    act   = 1'b0;
    m_op  = 2'b00;
    m_rem = 0;
    m_q   = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    logic [CNT_W+1:0] e;
    acc = cmd_valid && (fq.size() < DEPTH);
`ifdef JK_SEQ_CHECK_EN
    if (q_in !== m_q)
      m_err = 1'b1;
`endif
    if (act) begin
      case (m_op)
        2'd1:    m_q = 1'b0;
        2'd2:    m_q = 1'b1;
        2'd3:    m_q = !m_q;
        default: m_q = m_q;
      endcase
    end
    if (act && m_rem > 0) begin
      m_rem--;
    end else if (fq.size() > 0) begin
      e     = fq.pop_front();
      act   = 1'b1;
      m_op  = e[CNT_W+1:CNT_W];
      m_rem = int'(e[CNT_W-1:0]);
    end else begin
      act = 1'b0;
    end
    if (acc)
      fq.push_back({cmd_op, cmd_cnt});
  endtask

  task automatic check_all();
    chk("j", j, act && m_op[1]);
    chk("k", k, act && m_op[0]);
    chk("done", done, act && (m_rem == 0));
    chk("busy", busy, act || (fq.size() != 0));
    chk("ready", cmd_ready, fq.size() < DEPTH);
    chk("q_model", q_model, m_q);
    chk("err", err, m_err);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    q_in = force_q0 ? 1'b0 : m_q;
    check_all();
  endtask

  task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((act || fq.size() != 0) && n < 500) begin
      step();
      n++;
    end
    chk("drain_bound", n < 500, 1'b1);
    step();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    model_reset();
    q_in = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    force_q0 = 1'b0;
    model_reset();
    #100;
    reset = 1'b1;
    #1;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_j", j, 1'b0);
    chk("rst_k", k, 1'b0);
    chk("rst_q", q_model, 1'b0);
    repeat (3) step();

    send(2'd2, 4'd0);
    step();
    chk("t2_j", j, 1'b1);
    chk("t2_done", done, 1'b1);
    step();
    chk("t2_q", q_model, 1'b1);
    chk("t2_j_off", j, 1'b0);

    send(2'd3, 4'd3);
    repeat (4) step();
    chk("t3_done", done, 1'b1);
    step();
    chk("t3_q", q_model, 1'b1);
    chk("t3_j_off", j, 1'b0);

    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_op  = (i == 0) ? 2'd1 : 2'($urandom_range(0, 3));
      cmd_cnt = (i == 0) ? 4'd15 : 4'($urandom_range(0, 2));
      step();
      if (i == 4)
        chk("t4_full", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    drain();

    send(2'd3, 4'd7);
    send(2'd1, 4'd1);
    send(2'd2, 4'd1);
    step();
    chk("t5_mid_j", j, 1'b1);
    reset = 1'b0;
    #1;
    chk("t5_j", j, 1'b0);
    chk("t5_k", k, 1'b0);
    chk("t5_q", q_model, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    model_reset();
    q_in = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_cnt   = ($urandom_range(0, 7) == 0) ?
                  4'($urandom_range(0, 15)) :
                  4'($urandom_range(0, 3));
      step();
    end
    cmd_valid = 1'b0;
    drain();

`ifdef JK_SEQ_CHECK_EN
    force_q0 = 1'b1;
    q_in = 1'b0;
    send(2'd2, 4'd2);
    repeat (3) step();
    chk("t6_err", err, 1'b1);
    force_q0 = 1'b0;
    q_in = m_q;
    send(2'd3, 4'd1);
    drain();
    chk("t6_sticky", err, 1'b1);
    pulse_reset();
    chk("t6_clr", err, 1'b0);
`endif

    pulse_reset();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
